// File: rtl/digit_step_sched_pkg.sv
// Shared types and 7-segment constants for the digit step scheduler.
package digit_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_INC1 = 2'b01,
    OP_INC2 = 2'b10,
    OP_DEC1 = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPD,
    S_ACK
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/digit_step_sched_if.sv
// Requester-side req/op/gnt handshake bundle for digit_step_sched.
interface digit_step_sched_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]   req_i;
  logic [2*NREQ-1:0] op_i;
  logic [NREQ-1:0]   gnt_o;

  modport master (output req_i, output op_i, input gnt_o);
  modport slave  (input req_i, input op_i, output gnt_o);
endinterface

// File: rtl/digit_step_sched_seg7.sv
// Combinational digit to active-low 7-segment pattern; values above 9 blank.
module seg7_decoder
  import digit_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [DW-1:0] digit,
  output logic [6:0]    seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (32'(digit))
      0: seg = SEG_0;
      1: seg = SEG_1;
      2: seg = SEG_2;
      3: seg = SEG_3;
      4: seg = SEG_4;
      5: seg = SEG_5;
      6: seg = SEG_6;
      7: seg = SEG_7;
      8: seg = SEG_8;
      9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_step_sched.sv
// Round-robin scheduler applying step ops to one shared mod-MOD digit.
// Define SEG_DECODE_EN to drive a registered 7-segment decode on hex_o.
module digit_step_sched
  import digit_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MOD  = 10,
  parameter int DW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  digit_step_sched_if.slave    bus,
  output logic [DW-1:0]        digit_o,
  output logic                 wrap_o,
  output logic [6:0]           hex_o
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q, state_d;
  logic [RW-1:0]   rr_q, rr_d, win_q, win_d;
  op_t             op_q, op_d;
  logic [DW-1:0]   digit_d;
  logic [NREQ-1:0] gnt_d;
  logic            wrap_d;
  logic [DW:0]     sum;
  logic            found;
  int unsigned     idx;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    op_d    = op_q;
    digit_d = digit_o;
    gnt_d   = '0;
    wrap_d  = 1'b0;
    sum     = '0;
    found   = 1'b0;
    idx     = 0;
    case (state_q)
      S_IDLE: begin
        // Circular scan starting at the round-robin pointer
        for (int unsigned i = 0; i < NREQ; i++) begin
          idx = (32'(rr_q) + i) % NREQ;
          if (!found && bus.req_i[idx]) begin
            found   = 1'b1;
            win_d   = RW'(idx);
            op_d    = op_t'(bus.op_i[2*idx +: 2]);
            state_d = S_UPD;
          end
        end
      end
      S_UPD: begin
        case (op_q)
          OP_INC1, OP_INC2: begin
            sum = {1'b0, digit_o} + ((op_q == OP_INC2) ? (DW+1)'(2) : (DW+1)'(1));
            if (sum >= (DW+1)'(MOD)) begin
              sum    = sum - (DW+1)'(MOD);
              wrap_d = 1'b1;
            end
            digit_d = sum[DW-1:0];
          end
          OP_DEC1: begin
            if (digit_o == '0) begin
              digit_d = DW'(MOD - 1);
              wrap_d  = 1'b1;
            end else begin
              digit_d = digit_o - DW'(1);
            end
          end
          default: digit_d = digit_o;
        endcase
        gnt_d[win_q] = 1'b1;
        rr_d    = (32'(win_q) == NREQ - 1) ? '0 : win_q + RW'(1);
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Clear drops any latched op without a grant; rr pointer survives
    if (clr_i) begin
      state_d = S_IDLE;
      digit_d = '0;
      gnt_d   = '0;
      wrap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      win_q     <= '0;
      op_q      <= OP_HOLD;
      digit_o   <= '0;
      bus.gnt_o <= '0;
      wrap_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      op_q      <= op_d;
      digit_o   <= digit_d;
      bus.gnt_o <= gnt_d;
      wrap_o    <= wrap_d;
    end
  end

`ifdef SEG_DECODE_EN
  logic [6:0] seg_d;

  seg7_decoder #(.DW(DW)) u_seg (
    .digit (digit_d),
    .seg   (seg_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hex_o <= SEG_0;
    else        hex_o <= seg_d;
  end
`else
  assign hex_o = SEG_BLANK;
`endif

endmodule
